// File: rtl/signal_phase_sched.sv
// Two-road intersection phase scheduler: green/yellow/all-red/walk sequencing
// driven by vehicle demand on roads A and B and a latched pedestrian request.
module signal_phase_sched #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [1:0] lamp_a,
    output logic [1:0] lamp_b,
    output logic       walk,
    output logic [2:0] phase,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        AR_AB = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        AR_BA = 3'd6,
        WALK  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_T - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             next_road;
    logic             gap_ok;
    logic             max_hit;
    logic             in_green;
    logic             changing;

    assign gap_ok   = (timer >= T_GMIN);
    assign max_hit  = (timer == T_GMAX);
    assign in_green = (state == A_GRN) || (state == B_GRN);
    assign changing = (state_nx != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = A_GRN;
            end
            A_GRN: begin
                if ((req_b || ped_pending) &&
                    ((gap_ok && !req_a) || max_hit))
                    state_nx = A_YEL;
            end
            A_YEL: begin
                if (timer == T_YEL) state_nx = AR_AB;
            end
            AR_AB: begin
                if (timer == T_AR)
                    state_nx = ped_pending ? WALK : B_GRN;
            end
            B_GRN: begin
                if ((req_a || ped_pending) &&
                    ((gap_ok && !req_b) || max_hit))
                    state_nx = B_YEL;
            end
            B_YEL: begin
                if (timer == T_YEL) state_nx = AR_BA;
            end
            AR_BA: begin
                if (timer == T_AR)
                    state_nx = ped_pending ? WALK : A_GRN;
            end
            WALK: begin
                if (timer == T_WALK)
                    state_nx = next_road ? B_GRN : A_GRN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Green timer saturates so a long rest cannot wrap back under GREEN_MIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (changing || state == IDLE) begin
            timer <= '0;
        end else if (in_green && max_hit) begin
            timer <= timer;
        end else begin
            timer <= timer + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else if (state == IDLE) begin
            ped_pending <= ped_pending;
        end else if (state_nx == WALK && state != WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    // next_road: 0 = A, 1 = B; chosen when leaving all-red, even into WALK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_road <= 1'b0;
        end else if (state == AR_AB && changing) begin
            next_road <= 1'b1;
        end else if (state == AR_BA && changing) begin
            next_road <= 1'b0;
        end
    end

    always_comb begin
        lamp_a = 2'b00;
        lamp_b = 2'b00;
        walk   = 1'b0;
        unique case (state)
            A_GRN:   lamp_a = 2'b01;
            A_YEL:   lamp_a = 2'b10;
            B_GRN:   lamp_b = 2'b01;
            B_YEL:   lamp_b = 2'b10;
            WALK:    walk   = 1'b1;
            default: begin
                lamp_a = 2'b00;
                lamp_b = 2'b00;
            end
        endcase
    end

    assign phase = state;
    assign busy  = (state != IDLE);

endmodule
